// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the byte-level I2C bus master.
//   - command opcodes carried on cmd_op
//   - controller FSM states
//   - quarter-bit phase indices produced by the phase timer
package i2c_pkg;

  localparam logic [1:0] I2C_OP_START = 2'd0;
  localparam logic [1:0] I2C_OP_WRITE = 2'd1;
  localparam logic [1:0] I2C_OP_READ  = 2'd2;
  localparam logic [1:0] I2C_OP_STOP  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_STOP,
    ST_HOLD
  } i2c_state_t;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } i2c_quarter_t;

endpackage

// File: rtl/i2c_phase_timer.sv
// i2c_phase_timer: divides clk into quarter-bit phases for the I2C master.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         restart at the beginning of Q0 (new bus step)
//   en          count while a bus step is in progress
//   stall       hold at the last clk of the current quarter (SCL stretching)
//   q_end       strobe on the last clk of each quarter
//   quarter     current quarter index 0..3
module i2c_phase_timer #(
  parameter int DIV = 63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       stall,
  output logic       q_end,
  output logic [1:0] quarter
);
  import i2c_pkg::*;

  localparam logic [15:0] RELOAD = 16'(DIV - 1);

  logic [15:0] cnt;

  // Stall only gates the wrap, so a stretched quarter simply stays at its
  // last clk until the stall lifts.
  assign q_end = en && !clr && (cnt == 16'd0) && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= RELOAD;
      quarter <= Q0;
    end else if (clr) begin
      cnt     <= RELOAD;
      quarter <= Q0;
    end else if (en) begin
      if (cnt == 16'd0) begin
        if (!stall) begin
          cnt     <= RELOAD;
          quarter <= quarter + 2'd1;
        end
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_master.sv
// i2c_master: byte-level open-drain I2C bus master.
// Executes one command at a time (START, WRITE, READ, STOP) from a
// valid/ready port and reports completion on a one-cycle response strobe.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   scl_i, sda_i          bus line samples (2-flop synchronised inside)
//   scl_oe, sda_oe        1 = pull the line low; sda_o is tied 0
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                0=START 1=WRITE 2=READ 3=STOP
//   cmd_wdata             byte for WRITE, MSB first
//   cmd_nack              READ only: send NACK after the byte
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_nack   READ data / WRITE ack bit (1 = NACK)
//   rsp_err               command illegal in the current bus state
//   bus_active            high between our START and our STOP
// Build option: define I2C_MASTER_CLK_STRETCH_EN to let slaves stretch SCL
// (Q2 of every step waits for synchronised SCL high).
module i2c_master #(
  parameter int DIV = 63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  output logic       scl_oe,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_err,
  output logic       bus_active
);
  import i2c_pkg::*;

  i2c_state_t state, state_d;

  logic       scl_m1, scl_s, sda_m1, sda_s;
  logic       ready_q;
  logic [1:0] op_q;
  logic [7:0] wdata_q;
  logic       nack_q;
  logic [3:0] bit_idx;
  logic [7:0] shift_q;
  logic       ack_q;

  logic       accept, legal;
  logic       tmr_clr, tmr_en, stall, q_end;
  logic [1:0] quarter;
  logic       scl_oe_d, sda_oe_d, rsp_valid_d, rsp_err_d, rsp_nack_d;
  logic       bus_active_d, bit_drive, byte_done;
  logic [7:0] rsp_rdata_d;

  assign sda_o     = 1'b0;
  assign cmd_ready = ready_q;
  assign tmr_en    = (state == ST_START) || (state == ST_BIT) || (state == ST_STOP);

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // A slave holding SCL low keeps Q2 open until the line is seen high.
  assign stall = tmr_en && (quarter == Q2) && !scl_s;
`else
  assign stall = 1'b0;
`endif

  i2c_phase_timer #(
    .DIV(DIV)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .stall  (stall),
    .q_end  (q_end),
    .quarter(quarter)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    accept       = cmd_valid && ready_q;
    legal        = 1'b0;
    state_d      = state;
    scl_oe_d     = scl_oe;
    sda_oe_d     = sda_oe;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = rsp_err;
    rsp_nack_d   = rsp_nack;
    rsp_rdata_d  = rsp_rdata;
    bus_active_d = bus_active;
    tmr_clr      = 1'b0;
    byte_done    = (state == ST_BIT) && q_end && (quarter == Q3) && (bit_idx == 4'd8);

    // Level the master puts on SDA for the current bit slot (1 = pull low).
    if (op_q == I2C_OP_WRITE) begin
      bit_drive = (bit_idx == 4'd8) ? 1'b0 : ~wdata_q[3'd7 - bit_idx[2:0]];
    end else begin
      bit_drive = (bit_idx == 4'd8) ? ~nack_q : 1'b0;
    end

    case (state)
      ST_IDLE, ST_HOLD: begin
        if (state == ST_IDLE) begin
          scl_oe_d = 1'b0;
          sda_oe_d = 1'b0;
          legal    = (cmd_op == I2C_OP_START) && scl_s && sda_s;
        end else begin
          scl_oe_d = 1'b1;
          legal    = 1'b1;
        end
        if (accept) begin
          if (legal) begin
            tmr_clr = 1'b1;
            case (cmd_op)
              I2C_OP_START: state_d = ST_START;
              I2C_OP_WRITE: state_d = ST_BIT;
              I2C_OP_READ:  state_d = ST_BIT;
              default:      state_d = ST_STOP;
            endcase
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_nack_d  = 1'b0;
          end
        end
      end

      ST_START: begin
        case (quarter)
          Q0:      sda_oe_d = 1'b0;
          Q1:      scl_oe_d = 1'b0;
          default: sda_oe_d = 1'b1;
        endcase
        if (q_end && (quarter == Q3)) begin
          scl_oe_d     = 1'b1;
          state_d      = ST_HOLD;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b0;
          rsp_nack_d   = 1'b0;
          bus_active_d = 1'b1;
        end
      end

      ST_BIT: begin
        sda_oe_d = bit_drive;
        scl_oe_d = (quarter == Q0) || (quarter == Q1);
        if (q_end && (quarter == Q3)) begin
          scl_oe_d = 1'b1;
        end
        if (byte_done) begin
          state_d     = ST_HOLD;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (op_q == I2C_OP_WRITE) begin
            rsp_nack_d = ack_q;
          end else begin
            rsp_nack_d  = 1'b0;
            rsp_rdata_d = shift_q;
          end
        end
      end

      ST_STOP: begin
        case (quarter)
          Q0: begin
            sda_oe_d = 1'b1;
            scl_oe_d = 1'b1;
          end
          Q1:      scl_oe_d = 1'b0;
          default: sda_oe_d = 1'b0;
        endcase
        if (q_end && (quarter == Q3)) begin
          state_d      = ST_IDLE;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b0;
          rsp_nack_d   = 1'b0;
          bus_active_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers; line enables are registered so SCL/SDA
  // never see combinational glitches, and reset releases them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_m1     <= 1'b1;
      scl_s      <= 1'b1;
      sda_m1     <= 1'b1;
      sda_s      <= 1'b1;
      ready_q    <= 1'b0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_nack   <= 1'b0;
      rsp_rdata  <= 8'h00;
      bus_active <= 1'b0;
      bit_idx    <= 4'd0;
    end else begin
      scl_m1     <= scl_i;
      scl_s      <= scl_m1;
      sda_m1     <= sda_i;
      sda_s      <= sda_m1;
      ready_q    <= !accept && ((state_d == ST_IDLE) || (state_d == ST_HOLD));
      scl_oe     <= scl_oe_d;
      sda_oe     <= sda_oe_d;
      rsp_valid  <= rsp_valid_d;
      rsp_err    <= rsp_err_d;
      rsp_nack   <= rsp_nack_d;
      rsp_rdata  <= rsp_rdata_d;
      bus_active <= bus_active_d;
      if (accept && legal) begin
        bit_idx <= 4'd0;
      end else if ((state == ST_BIT) && q_end && (quarter == Q3) && (bit_idx != 4'd8)) begin
        bit_idx <= bit_idx + 4'd1;
      end
    end
  end

  // Command capture and received-bit shifting; SDA is sampled on the last
  // clk of Q2 while SCL is high.
  always_ff @(posedge clk) begin
    if (accept && legal) begin
      op_q    <= cmd_op;
      wdata_q <= cmd_wdata;
      nack_q  <= cmd_nack;
    end
    if ((state == ST_BIT) && q_end && (quarter == Q2)) begin
      if (bit_idx == 4'd8) begin
        ack_q <= sda_s;
      end else begin
        shift_q <= {shift_q[6:0], sda_s};
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
module tb_i2c_master;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_oe, sda_o, sda_oe;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_nack = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack, rsp_err, bus_active;

  logic slv_sda_low = 1'b0;
  logic slv_scl_low = 1'b0;
  logic force_sda_low = 1'b0;
  logic bscl, bsda;

  int total = 0;
  int bad = 0;

  assign bscl = ~scl_oe & ~slv_scl_low;
  assign bsda = ~sda_oe & ~slv_sda_low & ~force_sda_low;

  always #5 clk = ~clk;

  i2c_master #(.DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (bscl),
    .scl_oe    (scl_oe),
    .sda_i     (bsda),
    .sda_o     (sda_o),
    .sda_oe    (sda_oe),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_wdata (cmd_wdata),
    .cmd_nack  (cmd_nack),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nack  (rsp_nack),
    .rsp_err   (rsp_err),
    .bus_active(bus_active)
  );

  // Behavioural slave at address 0x70: logs every byte it receives, ACKs
  // when addressed, and transmits tx0 then tx1 on reads.
  logic       s_prev_scl = 1'b1, s_prev_sda = 1'b1;
  logic       s_active = 1'b0, s_in_addr = 1'b0, s_matched = 1'b0;
  logic       s_rw = 1'b0, s_tx = 1'b0, s_mack = 1'b0;
  int         s_bitcnt = 0;
  logic [7:0] s_sreg = 8'h00, s_txbyte = 8'h00;
  logic [1:0] s_txi = 2'd0;
  logic [7:0] tx0 = 8'h00, tx1 = 8'h00, tx_next;
  logic [7:0] rx_log[$];
  logic       ack_log[$];
  int         start_cnt = 0;

  assign tx_next = (s_txi == 2'd0) ? tx0 : tx1;

  always @(posedge clk) begin
    s_prev_scl <= bscl;
    s_prev_sda <= bsda;
    if (!rst_n) begin
      s_active    <= 1'b0;
      slv_sda_low <= 1'b0;
      s_tx        <= 1'b0;
    end else if (bscl && s_prev_scl && s_prev_sda && !bsda) begin
      s_active    <= 1'b1;
      s_bitcnt    <= 0;
      s_in_addr   <= 1'b1;
      s_tx        <= 1'b0;
      s_matched   <= 1'b0;
      s_txi       <= 2'd0;
      slv_sda_low <= 1'b0;
      start_cnt   <= start_cnt + 1;
    end else if (bscl && s_prev_scl && !s_prev_sda && bsda) begin
      s_active    <= 1'b0;
      slv_sda_low <= 1'b0;
      s_tx        <= 1'b0;
    end else if (s_active && bscl && !s_prev_scl) begin
      if (s_bitcnt < 8) begin
        s_sreg <= {s_sreg[6:0], bsda};
      end else if (s_tx) begin
        s_mack <= !bsda;
        ack_log.push_back(!bsda);
      end
      s_bitcnt <= s_bitcnt + 1;
    end else if (s_active && !bscl && s_prev_scl) begin
      if (s_bitcnt == 8) begin
        if (s_tx) begin
          slv_sda_low <= 1'b0;
        end else if (s_in_addr) begin
          rx_log.push_back(s_sreg);
          if (s_sreg[7:1] == 7'h70) begin
            slv_sda_low <= 1'b1;
            s_matched   <= 1'b1;
            s_rw        <= s_sreg[0];
          end else begin
            s_matched <= 1'b0;
          end
        end else if (s_matched) begin
          rx_log.push_back(s_sreg);
          slv_sda_low <= 1'b1;
        end
      end else if (s_bitcnt == 9) begin
        s_bitcnt  <= 0;
        s_in_addr <= 1'b0;
        if (s_matched && s_rw && (s_in_addr || (s_tx && s_mack))) begin
          s_tx        <= 1'b1;
          s_txbyte    <= tx_next;
          slv_sda_low <= ~tx_next[7];
          s_txi       <= s_txi + 2'd1;
        end else begin
          s_tx        <= 1'b0;
          slv_sda_low <= 1'b0;
        end
      end else if (s_tx && s_bitcnt >= 1 && s_bitcnt <= 7) begin
        slv_sda_low <= ~s_txbyte[7 - s_bitcnt];
      end
    end
  end

  // Issues one command from a negedge and returns at the negedge where
  // rsp_valid is seen; lat counts clocks from the accepting edge.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] wd, input logic nk,
                        output int lat, output logic [7:0] rd, output logic rn,
                        output logic er);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_wdata = wd;
    cmd_nack  = nk;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid !== 1'b1 && lat < 2000);
    if (lat >= 2000) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: op=%0d no rsp_valid within %0d clks", op, lat);
    end
    rd = rsp_rdata;
    rn = rsp_nack;
    er = rsp_err;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({scl_oe, sda_oe, sda_o, cmd_ready, rsp_valid, rsp_nack, rsp_err, bus_active} !== 8'h00 ||
        rsp_rdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: oe/ready/rsp=%b rdata=%h required all 0",
               {scl_oe, sda_oe, sda_o, cmd_ready, rsp_valid, rsp_nack, rsp_err, bus_active}, rsp_rdata);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_at_release: got %b required 0", cmd_ready);
    end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_release: got %b required 1", cmd_ready);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_ack();
    int lat, base;
    logic [7:0] rd;
    logic rn, er;
    base = rx_log.size();
    do_cmd(OP_START, 8'h00, 1'b0, lat, rd, rn, er);
    total++;
    if (lat !== 17 || er !== 1'b0 || bus_active !== 1'b1) begin
      bad++;
      $display("FAIL wr_start: lat=%0d err=%b active=%b required 17/0/1", lat, er, bus_active);
    end
    do_cmd(OP_WRITE, 8'hE0, 1'b0, lat, rd, rn, er);
    total++;
    if (lat !== 145 || rn !== 1'b0 || er !== 1'b0) begin
      bad++;
      $display("FAIL wr_addr: lat=%0d nack=%b err=%b required 145/0/0", lat, rn, er);
    end
    do_cmd(OP_WRITE, 8'h05, 1'b0, lat, rd, rn, er);
    total++;
    if (lat !== 145 || rn !== 1'b0) begin
      bad++;
      $display("FAIL wr_data: lat=%0d nack=%b required 145/0", lat, rn);
    end
    total++;
    if (scl_oe !== 1'b1 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_hold: scl_oe=%b ready=%b required 1/1", scl_oe, cmd_ready);
    end
    do_cmd(OP_STOP, 8'h00, 1'b0, lat, rd, rn, er);
    total++;
    if (lat !== 17 || bus_active !== 1'b0 || scl_oe !== 1'b0 || sda_oe !== 1'b0) begin
      bad++;
      $display("FAIL wr_stop: lat=%0d active=%b scl_oe=%b sda_oe=%b required 17/0/0/0",
               lat, bus_active, scl_oe, sda_oe);
    end
    total++;
    if (rx_log.size() != base + 2 || rx_log[base] !== 8'hE0 || rx_log[base+1] !== 8'h05) begin
      bad++;
      $display("FAIL wr_bus_bytes: count=%0d required 2 bytes E0 05", rx_log.size() - base);
    end
  endtask

  task automatic test_read();
    int lat, abase;
    logic [7:0] rd;
    logic rn, er;
    tx0 = 8'hA5;
    tx1 = 8'h3C;
    abase = ack_log.size();
    do_cmd(OP_START, 8'h00, 1'b0, lat, rd, rn, er);
    do_cmd(OP_WRITE, 8'hE1, 1'b0, lat, rd, rn, er);
    total++;
    if (rn !== 1'b0) begin
      bad++;
      $display("FAIL rd_addr_ack: nack=%b required 0", rn);
    end
    do_cmd(OP_READ, 8'h00, 1'b0, lat, rd, rn, er);
    total++;
    if (rd !== 8'hA5 || lat !== 145 || er !== 1'b0) begin
      bad++;
      $display("FAIL rd_byte0: rdata=%h lat=%0d err=%b required a5/145/0", rd, lat, er);
    end
    do_cmd(OP_READ, 8'h00, 1'b1, lat, rd, rn, er);
    total++;
    if (rd !== 8'h3C) begin
      bad++;
      $display("FAIL rd_byte1: rdata=%h required 3c", rd);
    end
    do_cmd(OP_STOP, 8'h00, 1'b0, lat, rd, rn, er);
    total++;
    if (rsp_rdata !== 8'h3C) begin
      bad++;
      $display("FAIL rd_hold_rdata: rdata=%h required 3c", rsp_rdata);
    end
    total++;
    if (ack_log.size() != abase + 2 || ack_log[abase] !== 1'b1 || ack_log[abase+1] !== 1'b0) begin
      bad++;
      $display("FAIL rd_master_ack: slots=%0d required 2 (ack then nack)", ack_log.size() - abase);
    end
  endtask

  task automatic test_addr_nack();
    int lat, loose;
    logic [7:0] rd;
    logic rn, er;
    do_cmd(OP_START, 8'h00, 1'b0, lat, rd, rn, er);
    do_cmd(OP_WRITE, 8'hE2, 1'b0, lat, rd, rn, er);
    total++;
    if (rn !== 1'b1 || er !== 1'b0) begin
      bad++;
      $display("FAIL nack_rsp: nack=%b err=%b required 1/0", rn, er);
    end
    loose = 0;
    repeat (40) begin
      @(negedge clk);
      if (scl_oe !== 1'b1 || bscl !== 1'b0) loose++;
    end
    total++;
    if (loose != 0 || bus_active !== 1'b1 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL nack_hold: scl_released_clks=%0d active=%b ready=%b required 0/1/1",
               loose, bus_active, cmd_ready);
    end
    do_cmd(OP_STOP, 8'h00, 1'b0, lat, rd, rn, er);
    total++;
    if (bus_active !== 1'b0 || bscl !== 1'b1 || bsda !== 1'b1) begin
      bad++;
      $display("FAIL nack_stop: active=%b scl=%b sda=%b required 0/1/1", bus_active, bscl, bsda);
    end
  endtask

  task automatic test_illegal();
    int lat, toggles;
    logic [7:0] rd;
    logic rn, er;
    toggles = 0;
    do_cmd(OP_WRITE, 8'h55, 1'b0, lat, rd, rn, er);
    total++;
    if (lat !== 1 || er !== 1'b1) begin
      bad++;
      $display("FAIL illegal_write: lat=%0d err=%b required 1/1", lat, er);
    end
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL illegal_ready_drop: ready=%b required 0", cmd_ready);
    end
    repeat (20) begin
      @(negedge clk);
      if (scl_oe !== 1'b0 || sda_oe !== 1'b0) toggles++;
    end
    total++;
    if (toggles != 0 || cmd_ready !== 1'b1 || bus_active !== 1'b0) begin
      bad++;
      $display("FAIL illegal_quiet: pulled_clks=%0d ready=%b active=%b required 0/1/0",
               toggles, cmd_ready, bus_active);
    end
    do_cmd(OP_STOP, 8'h00, 1'b0, lat, rd, rn, er);
    total++;
    if (lat !== 1 || er !== 1'b1) begin
      bad++;
      $display("FAIL illegal_stop: lat=%0d err=%b required 1/1", lat, er);
    end
    force_sda_low = 1'b1;
    repeat (5) @(negedge clk);
    do_cmd(OP_START, 8'h00, 1'b0, lat, rd, rn, er);
    total++;
    if (lat !== 1 || er !== 1'b1 || scl_oe !== 1'b0) begin
      bad++;
      $display("FAIL busy_start: lat=%0d err=%b scl_oe=%b required 1/1/0", lat, er, scl_oe);
    end
    force_sda_low = 1'b0;
    repeat (5) @(negedge clk);
    do_cmd(OP_START, 8'h00, 1'b0, lat, rd, rn, er);
    total++;
    if (er !== 1'b0 || bus_active !== 1'b1) begin
      bad++;
      $display("FAIL free_start: err=%b active=%b required 0/1", er, bus_active);
    end
    do_cmd(OP_STOP, 8'h00, 1'b0, lat, rd, rn, er);
  endtask

  task automatic test_repeated_start();
    int lat, s0;
    logic [7:0] rd;
    logic rn, er;
    tx0 = 8'h5A;
    s0 = start_cnt;
    do_cmd(OP_START, 8'h00, 1'b0, lat, rd, rn, er);
    do_cmd(OP_WRITE, 8'hE0, 1'b0, lat, rd, rn, er);
    do_cmd(OP_WRITE, 8'h00, 1'b0, lat, rd, rn, er);
    do_cmd(OP_START, 8'h00, 1'b0, lat, rd, rn, er);
    total++;
    if (lat !== 17 || er !== 1'b0 || bus_active !== 1'b1) begin
      bad++;
      $display("FAIL rstart_rsp: lat=%0d err=%b active=%b required 17/0/1", lat, er, bus_active);
    end
    do_cmd(OP_WRITE, 8'hE1, 1'b0, lat, rd, rn, er);
    do_cmd(OP_READ, 8'h00, 1'b1, lat, rd, rn, er);
    total++;
    if (rd !== 8'h5A) begin
      bad++;
      $display("FAIL rstart_read: rdata=%h required 5a", rd);
    end
    total++;
    if (start_cnt - s0 != 2) begin
      bad++;
      $display("FAIL rstart_count: starts=%0d required 2", start_cnt - s0);
    end
    do_cmd(OP_STOP, 8'h00, 1'b0, lat, rd, rn, er);
  endtask

  task automatic test_reset_mid_byte();
    int lat;
    logic [7:0] rd;
    logic rn, er;
    do_cmd(OP_START, 8'h00, 1'b0, lat, rd, rn, er);
    cmd_valid = 1'b1;
    cmd_op    = OP_WRITE;
    cmd_wdata = 8'h00;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (sda_oe !== 1'b1 || scl_oe !== 1'b1) begin
      bad++;
      $display("FAIL mid_byte_lines: scl_oe=%b sda_oe=%b required 1/1", scl_oe, sda_oe);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (scl_oe !== 1'b0 || sda_oe !== 1'b0 || bus_active !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: scl_oe=%b sda_oe=%b active=%b ready=%b required 0/0/0/0",
               scl_oe, sda_oe, bus_active, cmd_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

`ifdef I2C_MASTER_CLK_STRETCH_EN
  task automatic test_stretch();
    int lat, base;
    logic [7:0] rd;
    logic rn, er;
    base = rx_log.size();
    do_cmd(OP_START, 8'h00, 1'b0, lat, rd, rn, er);
    fork
      do_cmd(OP_WRITE, 8'hE0, 1'b0, lat, rd, rn, er);
      begin
        int falls, n;
        logic prev;
        falls = 0;
        n = 0;
        prev = scl_oe;
        while (falls < 4 && n < 400) begin
          @(negedge clk);
          n++;
          if (prev && !scl_oe) falls++;
          prev = scl_oe;
        end
        slv_scl_low = 1'b1;
        repeat (50) @(negedge clk);
        slv_scl_low = 1'b0;
      end
    join
    total++;
    if (lat !== 195 || rn !== 1'b0) begin
      bad++;
      $display("FAIL stretch_lat: lat=%0d nack=%b required 195/0", lat, rn);
    end
    total++;
    if (rx_log.size() != base + 1 || rx_log[base] !== 8'hE0) begin
      bad++;
      $display("FAIL stretch_data: count=%0d required 1 byte E0", rx_log.size() - base);
    end
    do_cmd(OP_STOP, 8'h00, 1'b0, lat, rd, rn, er);
  endtask
`endif

  initial begin
    test_reset();
    test_write_ack();
    test_read();
    test_addr_nack();
    test_illegal();
    test_repeated_start();
`ifdef I2C_MASTER_CLK_STRETCH_EN
    test_stretch();
`endif
    test_reset_mid_byte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
